// File: rtl/frame_sequencer.sv
// Frame sequencer: streams IMG_DIM*IMG_DIM pixels per frame from a FWFT FIFO to the CNN,
// then waits for the per-frame digit (or times out) and reports it, for NUM_FRAMES frames.
module frame_sequencer #(
  parameter int GS_BITS        = 8,
  parameter int BCD_BITS       = 4,
  parameter int IMG_DIM        = 30,
  parameter int NUM_FRAMES     = 1000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [GS_BITS-1:0]  fifo_dout,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic [GS_BITS-1:0]  pixel_o,
  output logic                pixel_o_valid,
  input  logic [BCD_BITS-1:0] digit_i,
  input  logic                digit_i_valid,
  output logic [BCD_BITS-1:0] result_o,
  output logic                result_valid_o,
  output logic [15:0]         result_frame_o,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic                proto_err
);

  localparam int PIX = IMG_DIM * IMG_DIM;
  localparam int PW  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0]       PIX_LAST     = PW'(PIX - 1);
  localparam logic [TW-1:0]       T_LAST       = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]         F_LAST       = 16'(NUM_FRAMES - 1);
  localparam logic [BCD_BITS-1:0] TIMEOUT_CODE = '1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [15:0]   fcnt;

  assign fifo_rd_en = (state == S_STREAM) && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      pcnt           <= '0;
      tcnt           <= '0;
      fcnt           <= '0;
      pixel_o        <= '0;
      pixel_o_valid  <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      result_frame_o <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      // pixel path: one register between FIFO head and CNN
      pixel_o_valid  <= fifo_rd_en;
      if (fifo_rd_en) pixel_o <= fifo_dout;
      result_valid_o <= 1'b0;
      done           <= 1'b0;
      // a digit outside WAIT has no frame to belong to
      if (digit_i_valid && state != S_WAIT) proto_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state       <= S_STREAM;
            busy        <= 1'b1;
            pcnt        <= '0;
            tcnt        <= '0;
            fcnt        <= '0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
          end
        end
        S_STREAM: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pcnt  <= '0;
            tcnt  <= '0;
            fcnt  <= '0;
          end else if (fifo_rd_en) begin
            if (pcnt == PIX_LAST) begin
              pcnt  <= '0;
              tcnt  <= '0;
              state <= S_WAIT;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pcnt  <= '0;
            tcnt  <= '0;
            fcnt  <= '0;
          end else if (digit_i_valid || tcnt == T_LAST) begin
            // a real digit beats a coincident timeout
            result_valid_o <= 1'b1;
            result_frame_o <= fcnt;
            result_o       <= digit_i_valid ? digit_i : TIMEOUT_CODE;
            if (!digit_i_valid) timeout_err <= 1'b1;
            tcnt <= '0;
            fcnt <= fcnt + 16'd1;
            if (fcnt == F_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_STREAM;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
